occ_tx_framer: RTL and testbench

//  Synthesizable TX-side word framer for the GTP link (16-bit, 8b/10b).

---
 rtl/occ_phy_pkg.sv | 17 +
 rtl/occ_tx_slot_ctr.sv | 35 +++
 rtl/occ_tx_framer.sv | 135 +++++++++++++
 tb/tb_occ_tx_framer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/occ_phy_pkg.sv
// occ_phy_pkg: shared IDLE K-word defaults and TX framer state encoding.
`default_nettype none

package occ_phy_pkg;

   localparam logic [15:0] c_IDLE   = 16'hbc95;
   localparam logic [1:0]  c_IDLE_K = 2'b10;

   typedef enum logic [1:0] {
      ST_DOWN   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/occ_tx_slot_ctr.sv
// occ_tx_slot_ctr: wrapping slot counter (0..PERIOD-1) with clear/enable; flags slot 0.
`default_nettype none

module occ_tx_slot_ctr #(
   parameter int PERIOD = 193,
   parameter int WIDTH  = 8
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr,
   input  logic en,
   output logic zero
);

   logic [WIDTH-1:0] slot;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         slot <= '0;
      end else if (clr) begin
         slot <= '0;
      end else if (en) begin
         if (slot == WIDTH'(PERIOD - 1)) begin
            slot <= '0;
         end else begin
            slot <= slot + WIDTH'(1);
         end
      end
   end

   assign zero = (slot == '0);

endmodule

`default_nettype wire

// File: rtl/occ_tx_framer.sv
// occ_tx_framer: merges a valid/ready payload stream with periodic IDLE K-words for the GT TX port,
// holding the line at IDLE until local and remote ends are ready, then sending a warm-up IDLE burst.
`default_nettype none

module occ_tx_framer
   import occ_phy_pkg::*;
#(
   parameter logic [15:0] g_IDLE         = c_IDLE,
   parameter logic [1:0]  g_IDLE_K       = c_IDLE_K,
   parameter int          g_IDLE_PERIOD  = 193,
   parameter int          g_WARMUP_IDLES = 16,
   parameter bit          g_FILL_TSTAMP  = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        tx_rdy_i,
   input  logic        remote_rdy_i,
   input  logic [15:0] s_data_i,
   input  logic        s_valid_i,
   output logic        s_ready_o,
   output logic [15:0] tx_data_o,
   output logic [1:0]  tx_k_o,
   output logic        running_o,
   output logic [31:0] data_cnt_o
);

   localparam int SLOT_W = $clog2(g_IDLE_PERIOD);
   localparam int WARM_W = $clog2(g_WARMUP_IDLES + 1);

   tx_state_t         state;
   logic [WARM_W-1:0] warm_cnt;
   logic [15:0]       tstamp;
   logic              remote_meta;
   logic              remote_sync;
   logic              rdy;
   logic              slot_zero;
   logic              in_run;
   logic              open_slot;
   logic              accept;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         remote_meta <= 1'b0;
         remote_sync <= 1'b0;
      end else begin
         remote_meta <= remote_rdy_i;
         remote_sync <= remote_meta;
      end
   end

   assign rdy       = tx_rdy_i & remote_sync;
   assign in_run    = (state == ST_RUN);
   assign open_slot = in_run & ~slot_zero & rdy;
   assign accept    = open_slot & s_valid_i;
   assign s_ready_o = open_slot;
   assign running_o = in_run;

   occ_tx_slot_ctr #(
      .PERIOD (g_IDLE_PERIOD),
      .WIDTH  (SLOT_W)
   ) u_slot_ctr (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr     (~in_run),
      .en      (in_run),
      .zero    (slot_zero)
   );

   // Warm-up lasts exactly g_WARMUP_IDLES cycles, each of which emits one IDLE.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= ST_DOWN;
         warm_cnt <= '0;
      end else begin
         case (state)
            ST_DOWN: begin
               warm_cnt <= '0;
               if (rdy) begin
                  state <= ST_WARMUP;
               end
            end
            ST_WARMUP: begin
               if (!rdy) begin
                  state    <= ST_DOWN;
                  warm_cnt <= '0;
               end else if (warm_cnt == WARM_W'(g_WARMUP_IDLES - 1)) begin
                  state    <= ST_RUN;
                  warm_cnt <= '0;
               end else begin
                  warm_cnt <= warm_cnt + WARM_W'(1);
               end
            end
            ST_RUN: begin
               if (!rdy) begin
                  state <= ST_DOWN;
               end
            end
            default: begin
               state    <= ST_DOWN;
               warm_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tstamp <= '0;
      end else begin
         tstamp <= tstamp + 16'd1;
      end
   end

   // Payload always leaves with k=00, even when it happens to equal the IDLE word.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tx_data_o  <= g_IDLE;
         tx_k_o     <= g_IDLE_K;
         data_cnt_o <= '0;
      end else if (accept) begin
         tx_data_o  <= s_data_i;
         tx_k_o     <= 2'b00;
         data_cnt_o <= data_cnt_o + 32'd1;
      end else if (open_slot && g_FILL_TSTAMP) begin
         tx_data_o  <= tstamp;
         tx_k_o     <= 2'b00;
      end else begin
         tx_data_o  <= g_IDLE;
         tx_k_o     <= g_IDLE_K;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_occ_tx_framer.sv
// tb_occ_tx_framer: directed bench for occ_tx_framer (IDLE hold, warm-up, slot framing, timestamp fill, resets).
`default_nettype none

module tb_occ_tx_framer;

   logic        clk = 1'b0;
   logic        rst_n, tx_rdy, remote_rdy, s_valid, s_ready, running;
   logic [15:0] s_data, tx_data;
   logic [1:0]  tx_k;
   logic [31:0] data_cnt;

   logic        rst2_n;
   logic        ts_ready, ts_running;
   logic [15:0] ts_data;
   logic [1:0]  ts_k;
   logic [31:0] ts_cnt;

   always #5 clk = ~clk;

   occ_tx_framer u_dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .tx_rdy_i     (tx_rdy),
      .remote_rdy_i (remote_rdy),
      .s_data_i     (s_data),
      .s_valid_i    (s_valid),
      .s_ready_o    (s_ready),
      .tx_data_o    (tx_data),
      .tx_k_o       (tx_k),
      .running_o    (running),
      .data_cnt_o   (data_cnt)
   );

   occ_tx_framer #(
      .g_IDLE_PERIOD  (5),
      .g_WARMUP_IDLES (3),
      .g_FILL_TSTAMP  (1'b1)
   ) u_dut_ts (
      .clk_i        (clk),
      .rst_n_i      (rst2_n),
      .tx_rdy_i     (1'b1),
      .remote_rdy_i (1'b1),
      .s_data_i     (16'h0000),
      .s_valid_i    (1'b0),
      .s_ready_o    (ts_ready),
      .tx_data_o    (ts_data),
      .tx_k_o       (ts_k),
      .running_o    (ts_running),
      .data_cnt_o   (ts_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   logic [15:0] sb[$];
   int  sb_bad = 0, emitted = 0;
   bit  run_chk = 0, saw_idle_payload = 0;
   int  run_len = 0, runs_done = 0, run_bad = 0;

   // One clock: record handshake, advance, then score the word now on the line.
   task automatic tick();
      logic acc;
      acc = s_valid && s_ready && rst_n;
      @(posedge clk);
      #1;
      if (acc) begin
         sb.push_back(s_data);
         s_data = s_data + 16'd1;
      end
      if (rst_n) begin
         if (tx_k == 2'b00) begin
            emitted++;
            if (sb.size() == 0) sb_bad++;
            else if (sb.pop_front() !== tx_data) sb_bad++;
            if (tx_data == 16'hbc95) saw_idle_payload = 1;
            run_len++;
         end else begin
            if (tx_data !== 16'hbc95 || tx_k !== 2'b10) sb_bad++;
            if (run_chk && run_len != 0) begin
               runs_done++;
               if (run_len != 192) run_bad++;
            end
            run_len = 0;
         end
      end
   endtask

   // Timestamp-fill instance: consecutive words step by 1, by 2 across each slot-0 IDLE.
   logic [15:0] ts_last;
   bit          ts_have = 0, ts_after_idle = 0;
   int          ts_bad = 0, ts_wraps = 0, ts_run = 0, ts_idles = 0;

   always @(negedge clk) begin
      if (rst2_n && ts_running) begin
         if (ts_k == 2'b00) begin
            if (ts_have) begin
               if (ts_data !== 16'(ts_last + (ts_after_idle ? 16'd2 : 16'd1))) ts_bad++;
               if (ts_data < ts_last) ts_wraps++;
            end
            ts_have       = 1;
            ts_last       = ts_data;
            ts_after_idle = 0;
            ts_run++;
         end else begin
            if (ts_data !== 16'hbc95 || ts_k !== 2'b10) ts_bad++;
            if (ts_have && ts_run != 4) ts_bad++;
            ts_run        = 0;
            ts_after_idle = 1;
            ts_idles++;
         end
      end
   end

   initial begin
      rst2_n = 1'b0;
      #22 rst2_n = 1'b1;
   end

   initial begin : main
      int n, first_rdy, first_dat, idles, rdy_hi, bad1;
      bit run18, run19;
      rst_n = 1'b0; tx_rdy = 1'b1; remote_rdy = 1'b0; s_valid = 1'b0; s_data = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_data",  tx_data,  16'hbc95);
      check("rst_k",     tx_k,     2'b10);
      check("rst_ready", s_ready,  1'b0);
      check("rst_run",   running,  1'b0);
      check("rst_cnt",   data_cnt, 32'd0);
      #1 rst_n = 1'b1;

      // Remote not ready: line must stay IDLE.
      rdy_hi = 0; bad1 = 0;
      repeat (100) begin
         tick();
         if (s_ready) rdy_hi++;
         if (tx_k !== 2'b10 || tx_data !== 16'hbc95) bad1++;
      end
      check("down_idle_words", bad1,   0);
      check("down_ready_high", rdy_hi, 0);

      // Remote ready: 2 sync + DOWN + 16 warm-up + slot 0 + 1 output latency.
      remote_rdy = 1'b1; s_valid = 1'b1; s_data = 16'hbc00; run_chk = 1;
      first_rdy = 0; first_dat = 0; run18 = 1; run19 = 0;
      for (n = 1; n <= 100; n++) begin
         tick();
         if (n == 18) run18 = running;
         if (n == 19) run19 = running;
         if (s_ready && first_rdy == 0) first_rdy = n;
         if (tx_k == 2'b00) begin
            first_dat = n;
            break;
         end
      end
      check("first_ready_cycle", first_rdy, 20);
      check("first_data_cycle",  first_dat, 21);
      check("warmup_not_run",    run18,     1'b0);
      check("run_at_slot0",      run19,     1'b1);
      check("first_data_word",   tx_data,   16'hbc00);
      check("first_data_cnt",    data_cnt,  32'd1);

      // Continuous payload: one IDLE every 193 words.
      repeat (1000) tick();
      check("stream_scoreboard", sb_bad,           0);
      check("stream_run_192",    run_bad,          0);
      check("stream_runs",       runs_done,        5);
      check("stream_data_cnt",   data_cnt,         32'd996);
      check("idle_payload_k00",  saw_idle_payload, 1'b1);
      run_chk = 0;

      // One-cycle tx_rdy drop: IDLE, then a full re-warm-up.
      repeat (7) tick();
      tx_rdy = 1'b0;
      #1 check("drop_ready", s_ready, 1'b0);
      tick();
      tx_rdy = 1'b1;
      check("drop_run", running, 1'b0);
      idles = (tx_k == 2'b10) ? 1 : 0;
      for (n = 0; n < 100; n++) begin
         tick();
         if (tx_k == 2'b00) break;
         idles++;
      end
      check("drop_idles",      idles,     19);
      check("drop_no_loss",    sb.size(), 0);
      check("drop_scoreboard", sb_bad,    0);
      repeat (50) tick();

      // Reset mid-RUN: outputs drop to IDLE immediately.
      rst_n = 1'b0;
      #1;
      check("mid_rst_data",  tx_data,  16'hbc95);
      check("mid_rst_k",     tx_k,     2'b10);
      check("mid_rst_run",   running,  1'b0);
      check("mid_rst_cnt",   data_cnt, 32'd0);
      check("mid_rst_ready", s_ready,  1'b0);
      sb.delete();
      repeat (3) tick();
      rst_n = 1'b1;
      first_dat = 0;
      for (n = 1; n <= 100; n++) begin
         tick();
         if (tx_k == 2'b00) begin
            first_dat = n;
            break;
         end
      end
      check("recover_data_cycle", first_dat, 21);
      check("recover_cnt",        data_cnt,  32'd1);
      repeat (300) tick();
      check("recover_scoreboard", sb_bad,   0);
      check("recover_data_cnt",   data_cnt, 32'd300);

      // Let the timestamp instance pass 16'hffff.
      repeat (66000) @(posedge clk);
      #1;
      check("ts_sequence", ts_bad,             0);
      check("ts_wrap",     ts_wraps,           1);
      check("ts_idles",    (ts_idles > 10000), 1'b1);
      check("ts_no_data",  ts_cnt,             32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
